switch_debounce4: RTL and testbench

//   Conditions four raw asynchronous switch/button inputs into clean, glitch-free

---
 rtl/switch_debounce4.sv | 147 ++++++++++++++
 tb/tb_switch_debounce4.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce4.sv
`default_nettype none
// ============================================================================
// Module   : switch_debounce4
// Brief    : Four-channel switch conditioner: N-flop synchronizer followed by
//            a stability-counter debouncer per channel, plus a post-reset
//            settle flag and a one-cycle change pulse. Defining DB_EDGE_EN
//            adds per-bit rise/fall pulse outputs.
// Revision : 1.0 - initial release
// ============================================================================
module switch_debounce4 #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 50000,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] raw_in,
    output logic [3:0] sw_out,
    output logic       valid,
    output logic       changed
`ifdef DB_EDGE_EN
    ,
    output logic [3:0] rise,
    output logic [3:0] fall
`endif
);

    localparam logic [0:0] ST_STABLE  = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    localparam int                SETTLE     = SYNC_STAGES + DB_CYCLES;
    localparam int                SET_W      = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [SET_W-1:0]  SETTLE_END = SET_W'(SETTLE);

    logic [3:0]       sync_q   [SYNC_STAGES];
    logic [3:0]       sync_d   [SYNC_STAGES];
    logic [0:0]       state_q  [4];
    logic [0:0]       state_d  [4];
    logic [CNT_W-1:0] cnt_q    [4];
    logic [CNT_W-1:0] cnt_d    [4];
    logic [3:0]       sw_out_q, sw_out_d;
    logic             changed_q, changed_d;
    logic             valid_q, valid_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [3:0]       sync_s;

    always_comb begin
        sync_d[0] = raw_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Per-channel debounce: a change is accepted only after DB_CYCLES
    // consecutive synchronized samples that differ from the current output.
    always_comb begin
        sw_out_d = sw_out_q;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_STABLE: begin
                    if (sync_s[i] != sw_out_q[i]) begin
                        state_d[i] = ST_PENDING;
                        cnt_d[i]   = CNT_W'(1);
                    end else begin
                        cnt_d[i]   = '0;
                    end
                end
                default: begin
                    if (sync_s[i] == sw_out_q[i]) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        sw_out_d[i] = sync_s[i];
                        state_d[i]  = ST_STABLE;
                        cnt_d[i]    = '0;
                    end else begin
                        cnt_d[i]    = cnt_q[i] + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        changed_d = |(sw_out_d ^ sw_out_q);
        settle_d  = (settle_q == SETTLE_END) ? settle_q : settle_q + SET_W'(1);
        valid_d   = valid_q | (settle_d == SETTLE_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
            sw_out_q  <= '0;
            changed_q <= 1'b0;
            valid_q   <= 1'b0;
            settle_q  <= '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            sw_out_q  <= sw_out_d;
            changed_q <= changed_d;
            valid_q   <= valid_d;
            settle_q  <= settle_d;
        end
    end

    assign sw_out  = sw_out_q;
    assign changed = changed_q;
    assign valid   = valid_q;

`ifdef DB_EDGE_EN
    logic [3:0] rise_q, rise_d;
    logic [3:0] fall_q, fall_d;

    always_comb begin
        rise_d = sw_out_d & ~sw_out_q;
        fall_d = ~sw_out_d & sw_out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce4.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_debounce4
// Brief    : Bench for switch_debounce4 (SYNC_STAGES=2, DB_CYCLES=4, CNT_W=3):
//            directed scenarios plus random input segments against a
//            run-length reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_debounce4;

    localparam int SYNC = 2;
    localparam int DB   = 4;
    localparam int CW   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] raw_in = 4'h0;
    logic [3:0] sw_out;
    logic       valid;
    logic       changed;
`ifdef DB_EDGE_EN
    logic [3:0] rise;
    logic [3:0] fall;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Reference model: raw delayed SYNC samples, then an output bit flips once
    // the delayed input has disagreed with it for DB consecutive samples.
    logic [3:0] m_pipe [SYNC];
    int         m_run  [4];
    logic [3:0] m_out, m_rise, m_fall;
    logic       m_chg, m_valid;
    int         m_settle;

    switch_debounce4 #(
        .SYNC_STAGES (SYNC),
        .DB_CYCLES   (DB),
        .CNT_W       (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .raw_in  (raw_in),
        .sw_out  (sw_out),
        .valid   (valid),
        .changed (changed)
`ifdef DB_EDGE_EN
        ,
        .rise    (rise),
        .fall    (fall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [3:0] r, input logic rs);
        logic [3:0] nxt;
        if (rs) begin
            for (int k = 0; k < SYNC; k++) m_pipe[k] = 4'h0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_out = 4'h0; m_rise = 4'h0; m_fall = 4'h0;
            m_chg = 1'b0; m_valid = 1'b0; m_settle = 0;
        end else begin
            nxt = m_out;
            for (int i = 0; i < 4; i++) begin
                if (m_pipe[SYNC-1][i] != m_out[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DB) begin
                        nxt[i]   = m_pipe[SYNC-1][i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_chg  = (nxt != m_out);
            m_rise = nxt & ~m_out;
            m_fall = ~nxt & m_out;
            m_out  = nxt;
            for (int k = SYNC - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
            m_pipe[0] = r;
            if (m_settle < SYNC + DB) m_settle++;
            m_valid = (m_settle >= SYNC + DB);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic rs);
        raw_in = r;
        rst    = rs;
        @(posedge clk);
        model_edge(r, rs);
        #1;
        check("sw_out", sw_out, m_out);
        check("valid", {3'b0, valid}, {3'b0, m_valid});
        check("changed", {3'b0, changed}, {3'b0, m_chg});
`ifdef DB_EDGE_EN
        check("rise", rise, m_rise);
        check("fall", fall, m_fall);
`endif
    endtask

    task automatic hold(input logic [3:0] r, input int n);
        for (int k = 0; k < n; k++) step(r, 1'b0);
    endtask

    initial begin
        // 1: reset with all inputs high, then release
        for (int k = 0; k < 3; k++) step(4'hF, 1'b1);
        check("rst_sw_out", sw_out, 4'h0);
        check("rst_valid", {3'b0, valid}, 4'h0);
        hold(4'hF, 5);
        check("s1_not_early", sw_out, 4'h0);
        check("s1_valid_early", {3'b0, valid}, 4'h0);
        hold(4'hF, 1);
        check("s1_sw_out", sw_out, 4'hF);
        check("s1_changed", {3'b0, changed}, 4'h1);
        check("s1_valid", {3'b0, valid}, 4'h1);
        hold(4'h0, 8);
        check("s1_back_low", sw_out, 4'h0);

        // 2: single bit rises
        hold(4'h1, 5);
        check("s2_not_early", sw_out, 4'h0);
        hold(4'h1, 1);
        check("s2_sw_out", sw_out, 4'h1);
        hold(4'h1, 6);

        // 3: short pulse on bit1 is rejected
        hold(4'h3, 3);
        hold(4'h1, 8);
        check("s3_rejected", sw_out, 4'h1);

        // 4: bounce on bit2 then hold
        step(4'h5, 1'b0);
        step(4'h1, 1'b0);
        hold(4'h5, 5);
        check("s4_not_early", sw_out, 4'h1);
        hold(4'h5, 1);
        check("s4_sw_out", sw_out, 4'h5);
        hold(4'h5, 4);

        // 5: multi-bit simultaneous change
        hold(4'h0, 8);
        hold(4'hA, 6);
        check("s5_sw_out", sw_out, 4'hA);
        check("s5_changed", {3'b0, changed}, 4'h1);
        hold(4'hA, 4);
        hold(4'h0, 8);

        // 6: reset during a pending change
        hold(4'h8, 4);
        step(4'h8, 1'b1);
        check("s6_rst_sw_out", sw_out, 4'h0);
        hold(4'h8, 5);
        check("s6_restart", sw_out, 4'h0);
        hold(4'h8, 1);
        check("s6_sw_out", sw_out, 4'h8);

        // Random segments with occasional resets
        for (int seg = 0; seg < 250; seg++) begin
            logic [3:0] r;
            int         n;
            r = 4'($urandom_range(0, 15));
            n = $urandom_range(1, 7);
            if ($urandom_range(0, 39) == 0) step(r, 1'b1);
            hold(r, n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
